// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Types and constants shared by the I2S input word-select decoder and the
// single-channel receivers that consume its capture windows.
//   ws_state_t              : decoder FSM state encoding
//   DEFAULT_BITS_PRECISION  : default bits captured per channel word
// ---------------------------------------------------------------------------
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_GAP   = 2'd3
    } ws_state_t;

    localparam int DEFAULT_BITS_PRECISION = 10;

endpackage

// File: rtl/i2sin_ws_decoder.sv
// ---------------------------------------------------------------------------
// i2sin_ws_decoder
// Tracks the I2S word-select line and opens one capture window per slot for
// the left and right single-channel receivers. Each window lasts exactly
// BITS_PRECISION sampling edges (MSB first), or less if the slot is cut short
// by an early ws edge.
//
// Ports
//   sck            in  : bit clock, all logic on its rising edge
//   rst            in  : synchronous active-high reset
//   ws             in  : word select (0 = left slot, 1 = right slot)
//   enable_left    out : left-channel capture window
//   enable_right   out : right-channel capture window
//   bit_index      out : bit captured on the next edge while a window is open
//   locked         out : a ws edge has been seen since reset
//   short_slot_err out : one-cycle pulse, slot ended before a full word
//   frame_done     out : one-cycle pulse as the right window closes
//   frame_count    out : number of frame_done pulses (wrapping)
// ---------------------------------------------------------------------------
module i2sin_ws_decoder
    import i2s_pkg::*;
#(
    parameter int BITS_PRECISION = DEFAULT_BITS_PRECISION,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                              sck,
    input  logic                              rst,
    input  logic                              ws,
    output logic                              enable_left,
    output logic                              enable_right,
    output logic [$clog2(BITS_PRECISION)-1:0] bit_index,
    output logic                              locked,
    output logic                              short_slot_err,
    output logic                              frame_done,
    output logic [FRAME_CNT_W-1:0]            frame_count
);

    localparam int              IDX_W  = $clog2(BITS_PRECISION);
    localparam logic [IDX_W-1:0] RELOAD = IDX_W'(BITS_PRECISION - 1);

    ws_state_t        state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic             ws_q_reg;
    logic             first_reg;
    logic             locked_reg, locked_next;
    logic             short_next;
    logic             frame_done_next;
    logic             ws_edge;
    ws_state_t        target_state;

    logic                   enable_left_reg;
    logic                   enable_right_reg;
    logic [IDX_W-1:0]       bit_index_reg;
    logic                   short_reg;
    logic                   frame_done_reg;
    logic [FRAME_CNT_W-1:0] frame_count_reg;

    // ws_q is loaded during reset, so the first cycle afterwards compares
    // against a value captured under reset; that comparison is ignored.
    assign ws_edge      = (ws != ws_q_reg) && !first_reg;
    assign target_state = ws ? ST_RIGHT : ST_LEFT;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        locked_next = locked_reg;
        short_next  = 1'b0;

        case (state_reg)
            ST_IDLE, ST_GAP: begin
                if (ws_edge) begin
                    state_next  = target_state;
                    cnt_next    = RELOAD;
                    locked_next = 1'b1;
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (ws_edge) begin
                    // Edge at counter 0 is a normal boundary; anything
                    // earlier truncates the word in flight.
                    state_next = target_state;
                    cnt_next   = RELOAD;
                    short_next = (cnt_reg != '0);
                end else if (cnt_reg == '0) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - IDX_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        frame_done_next = (state_reg == ST_RIGHT) && (state_next != ST_RIGHT);
    end

    // Outputs are decoded from the next state and registered so nothing
    // reaches an output combinationally from ws.
    always_ff @(posedge sck) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            ws_q_reg         <= ws;
            first_reg        <= 1'b1;
            locked_reg       <= 1'b0;
            enable_left_reg  <= 1'b0;
            enable_right_reg <= 1'b0;
            bit_index_reg    <= '0;
            short_reg        <= 1'b0;
            frame_done_reg   <= 1'b0;
            frame_count_reg  <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            ws_q_reg         <= ws;
            first_reg        <= 1'b0;
            locked_reg       <= locked_next;
            enable_left_reg  <= (state_next == ST_LEFT);
            enable_right_reg <= (state_next == ST_RIGHT);
            bit_index_reg    <= ((state_next == ST_LEFT) || (state_next == ST_RIGHT))
                                ? cnt_next : '0;
            short_reg        <= short_next;
            frame_done_reg   <= frame_done_next;
            if (frame_done_next) begin
                frame_count_reg <= frame_count_reg + FRAME_CNT_W'(1);
            end
        end
    end

    assign enable_left    = enable_left_reg;
    assign enable_right   = enable_right_reg;
    assign bit_index      = bit_index_reg;
    assign locked         = locked_reg;
    assign short_slot_err = short_reg;
    assign frame_done     = frame_done_reg;
    assign frame_count    = frame_count_reg;

endmodule

// File: tb/tb_i2sin_ws_decoder.sv
// ---------------------------------------------------------------------------
// tb_i2sin_ws_decoder
// Directed bench for the I2S word-select decoder (BITS_PRECISION = 10). A
// second instance with a 3-bit frame counter exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_i2sin_ws_decoder;

    localparam int B = 10;

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        ws  = 1'b1;

    logic        enable_left, enable_right, locked, short_slot_err, frame_done;
    logic [3:0]  bit_index;
    logic [15:0] frame_count;

    logic        s_enable_left, s_enable_right, s_locked, s_short_slot_err, s_frame_done;
    logic [3:0]  s_bit_index;
    logic [2:0]  s_frame_count;

    int checks = 0;
    int errors = 0;

    // run statistics gathered by observe()
    int both_cnt, gap_cnt, err_cnt, fd_cnt, bi_bad, len_l, len_r;
    int runs[$];

    i2sin_ws_decoder #(.BITS_PRECISION(B), .FRAME_CNT_W(16)) u_dut (
        .sck            (sck),
        .rst            (rst),
        .ws             (ws),
        .enable_left    (enable_left),
        .enable_right   (enable_right),
        .bit_index      (bit_index),
        .locked         (locked),
        .short_slot_err (short_slot_err),
        .frame_done     (frame_done),
        .frame_count    (frame_count)
    );

    i2sin_ws_decoder #(.BITS_PRECISION(B), .FRAME_CNT_W(3)) u_small (
        .sck            (sck),
        .rst            (rst),
        .ws             (ws),
        .enable_left    (s_enable_left),
        .enable_right   (s_enable_right),
        .bit_index      (s_bit_index),
        .locked         (s_locked),
        .short_slot_err (s_short_slot_err),
        .frame_done     (s_frame_done),
        .frame_count    (s_frame_count)
    );

    always #5 sck = ~sck;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic clear_stats();
        both_cnt = 0; gap_cnt = 0; err_cnt = 0; fd_cnt = 0; bi_bad = 0;
        len_l = 0; len_r = 0;
        runs.delete();
    endtask

    task automatic observe(input bit count_gap);
        if (enable_left && enable_right) both_cnt++;
        if (count_gap && locked && !enable_left && !enable_right) gap_cnt++;
        if (short_slot_err) err_cnt++;
        if (frame_done) fd_cnt++;
        if (enable_left) begin
            len_l++;
            if (int'(bit_index) != B - len_l) bi_bad++;
        end else if (len_l != 0) begin
            runs.push_back(len_l);
            len_l = 0;
        end
        if (enable_right) begin
            len_r++;
            if (int'(bit_index) != B - len_r) bi_bad++;
        end else if (len_r != 0) begin
            runs.push_back(len_r);
            len_r = 0;
        end
    endtask

    // Toggle ws every 'period' sck for 'nslots' slots, then hold ws for a tail
    // long enough for any open window to finish.
    task automatic run_slots(input int period, input int nslots);
        clear_stats();
        for (int s = 0; s < nslots; s++) begin
            @(negedge sck);
            ws = ~ws;
            for (int c = 0; c < period; c++) begin
                tick();
                observe(1'b1);
            end
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            observe(1'b0);
        end
    endtask

    // Every completed window except the last is expected to be 'len'; the
    // last one runs out to a full word during the tail.
    task automatic check_runs(input string tag, input int len);
        int bad;
        bad = 0;
        for (int i = 0; i < runs.size() - 1; i++) begin
            if (runs[i] != len) bad++;
        end
        check({tag, " run lengths"}, bad, 0);
        check({tag, " last run"}, runs[runs.size()-1], B);
    endtask

    task automatic do_reset(input logic ws_val);
        @(negedge sck);
        rst = 1'b1;
        ws  = ws_val;
        tick();
        tick();
        @(negedge sck);
        rst = 1'b0;
    endtask

    initial begin
        int found;
        int bad;

        // ---- reset state, ws held high (no edge) ----
        do_reset(1'b1);
        check("rst enable_left", enable_left, 0);
        check("rst enable_right", enable_right, 0);
        check("rst bit_index", bit_index, 0);
        check("rst locked", locked, 0);
        check("rst frame_count", frame_count, 0);

        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (locked || enable_left || enable_right || short_slot_err) bad++;
        end
        check("ws constant idle", bad, 0);

        // ---- first falling ws edge locks and opens the left window ----
        @(negedge sck);
        ws = 1'b0;
        tick();
        check("lock locked", locked, 1);
        check("lock enable_left", enable_left, 1);
        check("lock enable_right", enable_right, 0);
        check("lock bit_index msb", bit_index, B - 1);
        bad = 0;
        for (int k = 1; k < B; k++) begin
            tick();
            if (!enable_left || int'(bit_index) != B - 1 - k) bad++;
        end
        check("lock window 10 edges", bad, 0);
        tick();
        check("lock window closed", enable_left, 0);
        check("lock gap bit_index", bit_index, 0);
        check("lock no error", short_slot_err, 0);
        for (int c = 0; c < 20; c++) tick();

        // ---- ws every 32 sck: full windows separated by gaps ----
        run_slots(32, 4);
        check_runs("p32", B);
        check("p32 both high", both_cnt, 0);
        check("p32 short errors", err_cnt, 0);
        check("p32 gap cycles", gap_cnt, 4 * (32 - B));
        check("p32 frame_done", fd_cnt, 2);
        check("p32 bit_index seq", bi_bad, 0);

        // ---- ws every 10 sck: back-to-back handover ----
        run_slots(10, 6);
        check_runs("p10", B);
        check("p10 both high", both_cnt, 0);
        check("p10 short errors", err_cnt, 0);
        check("p10 gap cycles", gap_cnt, 0);
        check("p10 frame_done", fd_cnt, 3);
        check("p10 bit_index seq", bi_bad, 0);

        // ---- ws every 6 sck: every slot truncated ----
        run_slots(6, 6);
        check_runs("p6", 6);
        check("p6 both high", both_cnt, 0);
        check("p6 short errors", err_cnt, 5);
        check("p6 gap cycles", gap_cnt, 0);
        check("p6 frame_done", fd_cnt, 3);
        check("p6 bit_index seq", bi_bad, 0);
        check("p6 frame_count", frame_count, 8);
        check("p6 small frame_count", s_frame_count, 0);

        // ---- eight frames from reset, wrap on the 3-bit counter ----
        do_reset(1'b0);
        check("rst2 frame_count", frame_count, 0);
        run_slots(32, 16);
        check("8f frame_done", fd_cnt, 8);
        check("8f frame_count", frame_count, 8);
        check("8f small wrapped", s_frame_count, 0);
        run_slots(32, 2);
        check("9f frame_count", frame_count, 9);
        check("9f small after wrap", s_frame_count, 1);

        // ---- reset in the middle of a right slot ----
        @(negedge sck);
        ws = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (enable_right && bit_index == 4'd5) found = 1;
        end
        check("mid right bit5 reached", found, 1);
        @(negedge sck);
        rst = 1'b1;
        tick();
        check("mid rst enable_right", enable_right, 0);
        check("mid rst enable_left", enable_left, 0);
        check("mid rst bit_index", bit_index, 0);
        check("mid rst locked", locked, 0);
        check("mid rst short_err", short_slot_err, 0);
        check("mid rst frame_done", frame_done, 0);
        check("mid rst frame_count", frame_count, 0);
        tick();
        check("mid rst hold frame_done", frame_done, 0);
        @(negedge sck);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2sin_ws_decoder.md
I2SIN_WS_DECODER -- requirements
Module: i2sin_ws_decoder

Interface
REQ-001 The block SHALL have parameter BITS_PRECISION, default 10, giving bits per channel word captured; legal range 2..32.
REQ-002 The block SHALL have parameter FRAME_CNT_W, default 16, giving the width of the frame counter.
REQ-003 Port sck, input, 1 bit: the single clock; all logic SHALL use its rising edge.
REQ-004 Port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 Port ws, input, 1 bit: I2S word select, sampled on sck; 0 = left slot, 1 = right slot.
REQ-006 Port enable_left, output, 1 bit: capture window for the left-channel single-channel receiver.
REQ-007 Port enable_right, output, 1 bit: capture window for the right-channel single-channel receiver.
REQ-008 Port bit_index, output, $clog2(BITS_PRECISION) bits: index of the bit captured on the next edge while either enable is high (BITS_PRECISION-1 = MSB first); 0 otherwise.
REQ-009 Port locked, output, 1 bit: high once the first ws edge has been seen since reset.
REQ-010 Port short_slot_err, output, 1 bit: one-cycle pulse when a slot ends before BITS_PRECISION bits.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse when a right-slot window completes (full or truncated).
REQ-012 Port frame_count, output, FRAME_CNT_W bits: count of frame_done pulses.

Function
REQ-013 The block SHALL register ws into ws_q every cycle; a ws edge is ws != ws_q at a rising sck.
REQ-014 FSM states SHALL be IDLE, LEFT, RIGHT and GAP; only LEFT drives enable_left high and only RIGHT drives enable_right high.
REQ-015 IDLE: enables low and no ws edge detection on the first cycle after reset; on a ws edge, go to LEFT if ws=0 or RIGHT if ws=1, and set locked.
REQ-016 On a ws edge at edge n, the matching enable SHALL be high after edge n and stay high through edge n+BITS_PRECISION, i.e. exactly BITS_PRECISION sampling edges, MSB sampled at edge n+1.
REQ-017 A down-counter loaded with BITS_PRECISION-1 on entry SHALL drive bit_index and decrement each cycle in LEFT/RIGHT.
REQ-018 When the counter reaches 0 with no ws edge, the next state SHALL be GAP with enables low.
REQ-019 GAP: enables low; a ws edge enters LEFT or RIGHT per REQ-015.
REQ-020 A ws edge while in LEFT or RIGHT with counter > 0 SHALL pulse short_slot_err, drop the current enable and enter the opposite channel state with counter reloaded; the truncated word is delivered downstream as-is.
REQ-021 A ws edge coinciding with counter = 0 SHALL be a normal slot boundary: no error; enter the next channel directly, bypassing GAP.
REQ-022 frame_done SHALL pulse the cycle enable_right falls; frame_count SHALL increment on the same cycle, wrapping modulo 2^FRAME_CNT_W.
REQ-023 All outputs SHALL be registered; no combinational path from ws to any output.

Reset
REQ-024 While rst is high at a rising sck: state IDLE; enable_left, enable_right, locked, short_slot_err and frame_done = 0; bit_index = 0; frame_count = 0; counter = 0; ws_q <= ws.
REQ-025 rst asserted mid-slot SHALL drop enables on the next edge without short_slot_err or frame_done pulses.

Structure
REQ-026 The FSM state enum and the default BITS_PRECISION SHALL live in a shared package i2s_pkg for reuse by the receiver instances.
REQ-027 No sub-module is needed; the FSM and counter SHALL be implemented in this module.

Verification
REQ-028 B=10, ws toggling every 32 sck -> each enable high exactly 10 edges starting the edge after the ws edge; enables never both high; no short_slot_err.
REQ-029 ws toggling every 10 sck -> enables hand over back-to-back with no gap and no GAP state; no short_slot_err.
REQ-030 ws toggling every 6 sck in steady state -> short_slot_err pulses on each ws edge; each enable high 6 edges.
REQ-031 Eight full frames from reset -> frame_count = 8; frame_done pulsed 8 times; frame_count wraps 0xFFFF -> 0x0000 when preset near wrap.
REQ-032 ws held constant after reset -> locked = 0 and enables low indefinitely; first ws falling edge -> locked = 1 and enable_left starts.
REQ-033 rst asserted at bit_index = 5 of a right slot -> all outputs 0 on the next edge; frame_count = 0; no frame_done pulse.
